// File: rtl/cci_mpf_shim_rd_tag_heap.sv
// -----------------------------------------------------------------------------
// cci_mpf_shim_rd_tag_heap
//
// Read-channel tag allocator placed directly upstream of the EOP detection
// shim. Each read request has its Mdata replaced by a heap index that is
// unique while the request is in flight. The original AFU Mdata is saved and
// restored on every response flit. The index is returned to the free list
// only when the EOP flit of the packet comes back.
//
// Optional checking: define MPF_RD_TAG_HEAP_CHECK_EN to add a busy vector
// and a sticky protocol error flag (err). Without it, err is tied to 0.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   req_valid      AFU read request present
//   req_mdata      AFU Mdata to save for the request
//   req_rdy        a free tag is available and init is complete
//   req_tag        tag granted to the current request (combinational head)
//   rsp_valid      response flit from downstream
//   rsp_tag        low Mdata bits of the response (the heap index)
//   rsp_eop        last flit of the packet; frees the tag
//   rsp_valid_out  restored response valid (1 cycle after rsp_valid)
//   rsp_mdata      restored AFU Mdata
//   free_cnt       number of free tags (registered)
//   err            sticky protocol error (checking builds only)
// -----------------------------------------------------------------------------
module cci_mpf_shim_rd_tag_heap #(
  parameter int N_ENTRIES   = 128,
  parameter int MDATA_WIDTH = 16,
  parameter int N_IDX_BITS  = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [MDATA_WIDTH-1:0] req_mdata,
  output logic                   req_rdy,
  output logic [N_IDX_BITS-1:0]  req_tag,
  input  logic                   rsp_valid,
  input  logic [N_IDX_BITS-1:0]  rsp_tag,
  input  logic                   rsp_eop,
  output logic                   rsp_valid_out,
  output logic [MDATA_WIDTH-1:0] rsp_mdata,
  output logic [N_IDX_BITS:0]    free_cnt,
  output logic                   err
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [N_IDX_BITS:0]   PTR_ONE = {{N_IDX_BITS{1'b0}}, 1'b1};
  localparam logic [N_IDX_BITS-1:0] IDX_ONE = {{(N_IDX_BITS-1){1'b0}}, 1'b1};

  state_e                  state_q;
  logic [N_IDX_BITS-1:0]   init_idx_q;
  logic [N_IDX_BITS:0]     wr_ptr_q, rd_ptr_q;
  logic [N_IDX_BITS:0]     free_cnt_q, free_cnt_d;
  logic                    push_q;
  logic [N_IDX_BITS-1:0]   push_tag_q;
  logic                    rsp_valid_q;
  logic [MDATA_WIDTH-1:0]  rsp_mdata_q;

  logic [N_IDX_BITS-1:0]   free_mem  [N_ENTRIES];
  logic [MDATA_WIDTH-1:0]  mdata_mem [N_ENTRIES];

  logic                    run;
  logic                    pop;
  logic                    fifo_we;
  logic [N_IDX_BITS-1:0]   fifo_wdata;
  logic [N_IDX_BITS-1:0]   head;

  assign run        = (state_q == ST_RUN);
  assign head       = free_mem[rd_ptr_q[N_IDX_BITS-1:0]];
  assign req_tag    = head;
  assign req_rdy    = run && (free_cnt_q != '0);
  assign pop        = req_valid && req_rdy;
  // During INIT the write pointer tracks the init counter, so slot i gets i.
  assign fifo_we    = !run || push_q;
  assign fifo_wdata = run ? push_tag_q : init_idx_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    free_cnt_d = free_cnt_q;
    if (!run) begin
      free_cnt_d = free_cnt_q + PTR_ONE;
    end else begin
      case ({push_q, pop})
        2'b10:   free_cnt_d = free_cnt_q + PTR_ONE;
        2'b01:   free_cnt_d = free_cnt_q - PTR_ONE;
        default: free_cnt_d = free_cnt_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      free_cnt_q  <= '0;
      push_q      <= 1'b0;
      push_tag_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_mdata_q <= '0;
    end else begin
      free_cnt_q <= free_cnt_d;
      if (!run) begin
        init_idx_q <= init_idx_q + IDX_ONE;
        if (&init_idx_q) state_q <= ST_RUN;
      end
      if (fifo_we) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      // Free is registered: the tag lands on the free list one cycle after
      // its EOP flit, so it can be granted two cycles after the flit.
      push_q      <= rsp_valid && rsp_eop && run;
      push_tag_q  <= rsp_tag;
      rsp_valid_q <= rsp_valid && run;
      if (rsp_valid) rsp_mdata_q <= mdata_mem[rsp_tag];
    end
  end

  // NOTE: storage arrays are not reset; the free list is rebuilt by INIT and
  // mdata_mem is always written on allocation before it can be read.
  always_ff @(posedge clk) begin
    if (fifo_we) free_mem[wr_ptr_q[N_IDX_BITS-1:0]] <= fifo_wdata;
    if (pop)     mdata_mem[head] <= req_mdata;
  end

  assign rsp_valid_out = rsp_valid_q;
  assign rsp_mdata     = rsp_mdata_q;
  assign free_cnt      = free_cnt_q;

`ifdef MPF_RD_TAG_HEAP_CHECK_EN
  logic [N_ENTRIES-1:0] busy_q;
  logic                 err_q;
  logic                 full;

  // Full when the pointers differ only in their wrap bit.
  assign full = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {N_IDX_BITS{1'b0}}});

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (pop) busy_q[head] <= 1'b1;
      if (rsp_valid && rsp_eop && run) busy_q[rsp_tag] <= 1'b0;
      // A non-busy target covers both stray responses and double frees.
      if (rsp_valid && run && !busy_q[rsp_tag]) begin
        err_q <= 1'b1;
        $error("rd_tag_heap: response/free of non-busy tag %0d", rsp_tag);
      end
      if (pop && busy_q[head]) begin
        err_q <= 1'b1;
        $error("rd_tag_heap: allocate of busy tag %0d", head);
      end
      if (push_q && full) begin
        err_q <= 1'b1;
        $error("rd_tag_heap: push to full free list");
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
